vga_config_loader: RTL

Configuration sequencer that sits directly upstream of `VGA_Control` on its configuration port. It streams a fixed table of timing values over the `C_valid`/`C_addr`/`C_data`/`C_rdy` handshake:

- H/V left margin, right margin, sync pulse and count max.
- The table is chosen from a small set of resolution profiles.

It runs on the display clock. It loads the display timing after reset, or on request, without a processor in the loop.

---
 rtl/vga_config_loader_pkg.sv | 30 +++
 rtl/vga_config_rom.sv | 26 ++
 rtl/vga_config_loader.sv | 109 ++++++++++
 3 files changed

// File: rtl/vga_config_loader_pkg.sv
// Shared VGA configuration constants: register addresses, profile timing tables
// and the loader FSM state type.
package vga_config_loader_pkg;

   localparam int CONFIG_WIDTH = 4;
   localparam int TABLE_DEPTH  = 8;

   localparam int ADDR_H_LEFT  = 0;
   localparam int ADDR_V_LEFT  = 1;
   localparam int ADDR_H_RIGHT = 2;
   localparam int ADDR_V_RIGHT = 3;
   localparam int ADDR_H_SYNC  = 4;
   localparam int ADDR_V_SYNC  = 5;
   localparam int ADDR_H_MAX   = 6;
   localparam int ADDR_V_MAX   = 7;

   typedef logic [CONFIG_WIDTH-1:0] cfg_t;

   // Entries in address order H_Left, V_Left, H_Right, V_Right, H_Sync, V_Sync, H_Max, V_Max
   localparam cfg_t PROFILE0_TABLE [TABLE_DEPTH] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1, 4'd0, 4'd10, 4'd12};
   localparam cfg_t PROFILE1_TABLE [TABLE_DEPTH] = '{4'd2, 4'd2, 4'd9, 4'd9, 4'd1, 4'd1, 4'd14, 4'd15};

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      DONE,
      ERR
   } state_t;

endpackage

// File: rtl/vga_config_rom.sv
// Combinational (profile, index) -> register value lookup for the config loader.
module vga_config_rom #(
   parameter int CONFIG_WIDTH = 4,
   parameter int PROF_W       = 1,
   parameter int IDX_W        = 3
) (
   input  logic [PROF_W-1:0]       profile,
   input  logic [IDX_W-1:0]        index,
   output logic [CONFIG_WIDTH-1:0] data
);
   import vga_config_loader_pkg::*;

   // Profile 1 selects the second table; every other profile uses profile 0
   always_comb begin
      data = '0;
      for (int unsigned i = 0; i < TABLE_DEPTH; i++) begin
         if (32'(index) == i) begin
            if (profile == PROF_W'(1))
               data = CONFIG_WIDTH'(PROFILE1_TABLE[i]);
            else
               data = CONFIG_WIDTH'(PROFILE0_TABLE[i]);
         end
      end
   end

endmodule

// File: rtl/vga_config_loader.sv
// Streams a fixed VGA timing table over the C_valid/C_rdy configuration port,
// after reset (optional) or on Start, with a stall timeout.
module vga_config_loader #(
   parameter int CONFIG_WIDTH = vga_config_loader_pkg::CONFIG_WIDTH,
   parameter int NUM_ENTRIES  = 8,
   parameter int NUM_PROFILES = 2,
   parameter int TIMEOUT      = 255,
   parameter int AUTO_START   = 1,
   localparam int PROF_W      = (NUM_PROFILES > 1) ? $clog2(NUM_PROFILES) : 1
) (
   input  logic                    Clk,
   input  logic                    Rst,
   input  logic                    Start,
   input  logic [PROF_W-1:0]       Mode_sel,
   input  logic                    C_rdy,
   output logic                    C_valid,
   output logic [CONFIG_WIDTH-1:0] C_addr,
   output logic [CONFIG_WIDTH-1:0] C_data,
   output logic                    Busy,
   output logic                    Done,
   output logic                    Error
);
   import vga_config_loader_pkg::*;

   localparam int IDX_W = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   state_t              state, state_next;
   logic [IDX_W-1:0]    index, index_next;
   logic [CNT_W-1:0]    wait_cnt, wait_cnt_next;
   logic [PROF_W-1:0]   profile, profile_next;
   logic                auto_pend;
   logic                start_req;
   logic [PROF_W-1:0]   start_sel;
   logic [CONFIG_WIDTH-1:0] rom_data;

   vga_config_rom #(
      .CONFIG_WIDTH (CONFIG_WIDTH),
      .PROF_W       (PROF_W),
      .IDX_W        (IDX_W)
   ) u_rom (
      .profile (profile),
      .index   (index),
      .data    (rom_data)
   );

   // auto_pend is armed by reset and turns the first post-release cycle into a profile-0 Start
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state     <= IDLE;
         index     <= '0;
         wait_cnt  <= '0;
         profile   <= '0;
         auto_pend <= (AUTO_START != 0);
      end else begin
         state     <= state_next;
         index     <= index_next;
         wait_cnt  <= wait_cnt_next;
         profile   <= profile_next;
         auto_pend <= 1'b0;
      end
   end

   always_comb begin
      state_next    = state;
      index_next    = index;
      wait_cnt_next = wait_cnt;
      profile_next  = profile;
      start_req     = Start || auto_pend;
      if (auto_pend || int'(Mode_sel) >= NUM_PROFILES)
         start_sel = '0;
      else
         start_sel = Mode_sel;

      case (state)
         IDLE, DONE, ERR: begin
            if (start_req) begin
               state_next    = SEND;
               index_next    = '0;
               wait_cnt_next = '0;
               profile_next  = start_sel;
            end
         end
         SEND: begin
            // A transfer on the same edge as the timeout wins
            if (C_rdy) begin
               wait_cnt_next = '0;
               if (index == IDX_W'(NUM_ENTRIES - 1))
                  state_next = DONE;
               else
                  index_next = index + IDX_W'(1);
            end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
               state_next = ERR;
            end else begin
               wait_cnt_next = wait_cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign C_valid = (state == SEND);
   assign Busy    = (state == SEND);
   assign Done    = (state == DONE);
   assign Error   = (state == ERR);
   assign C_addr  = C_valid ? CONFIG_WIDTH'(index) : '0;
   assign C_data  = C_valid ? rom_data : '0;

endmodule
